pll_reset_seq: RTL



---
 rtl/pll_reset_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock monitor and system reset sequencer
//
// Ports:
//   clkin        in   1           25 MHz reference clock, valid regardless of PLL lock
//   rst          in   1           synchronous active-high reset
//   locked_async in   1           PLL lock flag, asynchronous to clkin
//   sw_reset_req in   1           single-cycle request forcing a full re-sequence
//   sys_rst      out  1           active-high reset for the PLL-clocked logic
//   ready        out  1           high exactly while the sequencer is in RUN
//   state        out  2           WAIT=0, STABLE=1, RUN=2, FORCE=3
//   loss_count   out  LOSS_CNT_W  saturating count of lock losses seen in RUN

module pll_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic                  locked_async,
    input  logic                  sw_reset_req,
    output logic                  sys_rst,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STABLE = 2'd1,
        S_RUN    = 2'd2,
        S_FORCE  = 2'd3
    } state_t;

    // One counter serves both the lock qualification and the forced hold,
    // so it is sized for whichever limit is larger.
    localparam int MAX_LIMIT = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W     = (MAX_LIMIT > 1) ? $clog2(MAX_LIMIT) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    state_t                 st;
    logic [CNT_W-1:0]       cnt;

    // Only the last synchroniser stage is safe to use in the FSM.
    assign locked_s = sync_q[SYNC_STAGES-1];
    assign state    = st;

    always_ff @(posedge clkin) begin
        if (rst) begin
            sync_q     <= '0;
            st         <= S_WAIT;
            cnt        <= '0;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            loss_count <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_async};

            // Loss accounting is independent of the next-state choice so a
            // software request on the same cycle still records the loss.
            if (st == S_RUN && !locked_s && loss_count != {LOSS_CNT_W{1'b1}}) begin
                loss_count <= loss_count + 1'b1;
            end

            if (sw_reset_req) begin
                // Overrides every other transition; in FORCE it restarts the hold.
                st      <= S_FORCE;
                cnt     <= '0;
                sys_rst <= 1'b1;
                ready   <= 1'b0;
            end else begin
                case (st)
                    S_WAIT: begin
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
                        if (locked_s) begin
                            st  <= S_STABLE;
                            cnt <= '0;
                        end
                    end

                    S_STABLE: begin
                        // Any low cycle sends qualification back to the start.
                        if (!locked_s) begin
                            st <= S_WAIT;
                        end else if (cnt == STABLE_LAST) begin
                            st      <= S_RUN;
                            sys_rst <= 1'b0;
                            ready   <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    S_RUN: begin
                        if (!locked_s) begin
                            st      <= S_WAIT;
                            sys_rst <= 1'b1;
                            ready   <= 1'b0;
                        end
                    end

                    S_FORCE: begin
                        // Lock is deliberately ignored until the hold expires.
                        if (cnt == HOLD_LAST) begin
                            st <= S_WAIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    default: begin
                        st      <= S_WAIT;
                        sys_rst <= 1'b1;
                        ready   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
